// File: rtl/fetch_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : fetch_ctrl                                                 |
// | Description : Instruction-fetch sequencing controller. Decides when the  |
// |               PC register is written and what it is loaded with. It      |
// |               handles boot delay, pipeline stalls, taken-branch          |
// |               redirects (one flush cycle) and halt/resume.               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   DATA_WIDTH    width of the PC / branch target (default 32)             |
// |   BOOT_CYCLES   post-reset cycles before the first fetch, 1..15          |
// | Ports                                                                    |
// |   clk           clock, all state changes on the rising edge              |
// |   rst           asynchronous active-high reset                           |
// |   stall_req     downstream cannot accept an instruction this cycle       |
// |   branch_taken  execute stage resolved a taken branch/jump               |
// |   branch_target redirect address, valid with branch_taken                |
// |   halt_req      freeze fetch (ecall/ebreak/debug)                        |
// |   resume        single-cycle pulse that leaves HALT                      |
// |   trigger       PC register write enable                                 |
// |   PCSrc         PC next-value select (0 = PC+4, 1 = PCTarget)            |
// |   PCTarget      latched redirect address                                 |
// |   flush         kill the instruction in fetch/decode                     |
// |   fetch_valid   fetched instruction is valid this cycle                  |
// |   halted        controller is in HALT                                    |
// |   stall_cycles  (FETCH_CTRL_PERFCNT_EN) saturating stalled-RUN count     |
// |   redirect_count(FETCH_CTRL_PERFCNT_EN) saturating REDIRECT-entry count  |
// | Optional feature macro: FETCH_CTRL_PERFCNT_EN                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int BOOT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_req,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  trigger,
    output logic                  PCSrc,
    output logic [DATA_WIDTH-1:0] PCTarget,
    output logic                  flush,
    output logic                  fetch_valid,
    output logic                  halted
`ifdef FETCH_CTRL_PERFCNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           redirect_count
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam logic [3:0] c_BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t                r_state;
    logic [3:0]            r_boot_cnt;
    logic [DATA_WIDTH-1:0] r_target;
    logic                  r_run;       // registered "state is RUN"
    logic                  r_redirect;  // registered "state is REDIRECT"
    logic                  r_halted;

    // Any of these blocks the normal sequential PC advance while in RUN.
    logic w_hold;
    assign w_hold = stall_req | branch_taken | halt_req;

    // REDIRECT always writes the PC (with the target); RUN writes PC+4 only
    // when nothing holds it. Combinational on purpose: stall must act in
    // the same cycle it is raised.
    assign trigger     = r_redirect | (r_run & ~w_hold);
    assign PCSrc       = r_redirect;
    assign flush       = r_redirect;
    assign fetch_valid = r_run;
    assign halted      = r_halted;
    assign PCTarget    = r_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_boot_cnt <= 4'd0;
            r_target   <= '0;
            r_run      <= 1'b0;
            r_redirect <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (r_boot_cnt == c_BOOT_LAST) begin
                        r_state <= ST_RUN;
                        r_run   <= 1'b1;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    // halt wins over a simultaneous branch, which is dropped
                    if (halt_req) begin
                        r_state  <= ST_HALT;
                        r_run    <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (branch_taken) begin
                        r_state    <= ST_REDIRECT;
                        r_target   <= branch_target;
                        r_run      <= 1'b0;
                        r_redirect <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    r_redirect <= 1'b0;
                    if (halt_req) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_run   <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (resume && !halt_req) begin
                        r_state  <= ST_RUN;
                        r_run    <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_BOOT;
                    r_boot_cnt <= 4'd0;
                    r_run      <= 1'b0;
                    r_redirect <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CTRL_PERFCNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_redirect_count;

    assign stall_cycles   = r_stall_cycles;
    assign redirect_count = r_redirect_count;

    // Only a pure stall counts; a branch or halt in the same cycle is
    // attributed to that event instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles   <= 32'd0;
            r_redirect_count <= 32'd0;
        end else if (r_run) begin
            if (stall_req && !branch_taken && !halt_req &&
                (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (branch_taken && !halt_req &&
                (r_redirect_count != 32'hFFFF_FFFF)) begin
                r_redirect_count <= r_redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_fetch_ctrl                                              |
// | Description : Scoreboard bench for fetch_ctrl. A behavioural model of    |
// |               the fetch rules predicts each cycle's outputs and the       |
// |               architectural PC; a monitor compares on the falling edge.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_ctrl;

    localparam int c_DW   = 32;
    localparam int c_BOOT = 2;

    logic            clk;
    logic            rst;
    logic            stall_req;
    logic            branch_taken;
    logic [c_DW-1:0] branch_target;
    logic            halt_req;
    logic            resume;
    logic            trigger;
    logic            PCSrc;
    logic [c_DW-1:0] PCTarget;
    logic            flush;
    logic            fetch_valid;
    logic            halted;
`ifdef FETCH_CTRL_PERFCNT_EN
    logic [31:0]     stall_cycles;
    logic [31:0]     redirect_count;
`endif

    fetch_ctrl #(.DATA_WIDTH(c_DW), .BOOT_CYCLES(c_BOOT)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .trigger       (trigger),
        .PCSrc         (PCSrc),
        .PCTarget      (PCTarget),
        .flush         (flush),
        .fetch_valid   (fetch_valid),
        .halted        (halted)
`ifdef FETCH_CTRL_PERFCNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .redirect_count(redirect_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The PC register the controller steers (environment, not the model).
    logic [31:0] pc_reg;
    always @(posedge clk or posedge rst) begin
        if (rst)          pc_reg <= 32'd0;
        else if (trigger) pc_reg <= PCSrc ? PCTarget : pc_reg + 32'd4;
    end

    typedef struct packed {
        logic        trig;
        logic        pcsrc;
        logic        flush;
        logic        fv;
        logic        halted;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] sc;
        logic [31:0] rc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // ---------------- reference model ----------------
    // Modes: 0 boot, 1 running, 2 redirect bubble, 3 halted.
    int          m_mode;
    int          m_boot_left;
    logic [31:0] m_pc, m_tgt, m_sc, m_rc;

    task automatic model_reset();
        m_mode      = 0;
        m_boot_left = c_BOOT;
        m_pc        = 32'd0;
        m_tgt       = 32'd0;
        m_sc        = 32'd0;
        m_rc        = 32'd0;
    endtask

    // Apply inputs for one cycle, predict outputs, advance model, step clock.
    task automatic cycle(input logic s, input logic b, input logic h,
                         input logic r, input logic [31:0] t);
        exp_t e;
        stall_req     = s;
        branch_taken  = b;
        halt_req      = h;
        resume        = r;
        branch_target = t;
        e = '0;
        e.tgt = m_tgt;
        e.pc  = m_pc;
        e.sc  = m_sc;
        e.rc  = m_rc;
        if (m_mode == 0) begin
            m_boot_left--;
            if (m_boot_left == 0) m_mode = 1;
        end else if (m_mode == 1) begin
            e.fv   = 1'b1;
            e.trig = !(s || b || h);
            if (e.trig) m_pc = m_pc + 32'd4;
            if (h) m_mode = 3;
            else if (b) begin
                m_tgt  = t;
                m_mode = 2;
                if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 32'd1;
            end else if (s && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
        end else if (m_mode == 2) begin
            e.trig  = 1'b1;
            e.pcsrc = 1'b1;
            e.flush = 1'b1;
            m_pc    = m_tgt;
            m_mode  = h ? 3 : 1;
        end else begin
            e.halted = 1'b1;
            if (r && !h) m_mode = 1;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic ok;
            e  = q.pop_front();
            ok = ({trigger, PCSrc, flush, fetch_valid, halted} ===
                  {e.trig, e.pcsrc, e.flush, e.fv, e.halted}) &&
                 (PCTarget === e.tgt) && (pc_reg === e.pc);
`ifdef FETCH_CTRL_PERFCNT_EN
            ok = ok && (stall_cycles === e.sc) && (redirect_count === e.rc);
`endif
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL cycle t=%0t: got trig/src/fl/fv/h=%b%b%b%b%b tgt=%h pc=%h, want %b%b%b%b%b tgt=%h pc=%h",
                         $time, trigger, PCSrc, flush, fetch_valid, halted, PCTarget, pc_reg,
                         e.trig, e.pcsrc, e.flush, e.fv, e.halted, e.tgt, e.pc);
            end
        end
    end

    // Assert reset mid-cycle and check that everything clears at once.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        checks++;
        if ({trigger, PCSrc, flush, fetch_valid, halted} !== 5'b0 ||
            PCTarget !== 32'd0 || pc_reg !== 32'd0) begin
            errors++;
            $display("FAIL %s: outputs=%b tgt=%h pc=%h, want 00000 tgt=0 pc=0",
                     tag, {trigger, PCSrc, flush, fetch_valid, halted}, PCTarget, pc_reg);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        stall_req     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        halt_req      = 1'b0;
        resume        = 1'b0;
        model_reset();
        #2;
        do_reset("reset_initial");

        // boot, then straight-line fetch
        repeat (5) cycle(0, 0, 0, 0, 32'd0);
        // three-cycle stall
        repeat (3) cycle(1, 0, 0, 0, 32'd0);
        cycle(0, 0, 0, 0, 32'd0);
        // branch to 0x40 (with stall also high: branch still wins)
        cycle(1, 1, 0, 0, 32'h40);
        cycle(1, 1, 0, 0, 32'h999);   // redirect ignores stall/branch
        repeat (2) cycle(0, 0, 0, 0, 32'd0);
        // halt beats a simultaneous branch to 0x80
        cycle(0, 1, 1, 0, 32'h80);
        cycle(0, 1, 0, 0, 32'h84);
        cycle(0, 0, 1, 1, 32'd0);     // halt+resume keeps HALT
        cycle(0, 0, 0, 1, 32'd0);     // resume
        repeat (2) cycle(0, 0, 0, 0, 32'd0);
        // reset while in REDIRECT toward 0x100
        cycle(0, 1, 0, 0, 32'h100);
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL redirect_before_reset: flush=%b, want 1", flush);
        end
        do_reset("reset_in_redirect");
        repeat (6) cycle(0, 0, 0, 0, 32'd0);
        // reset while halted
        cycle(0, 0, 1, 0, 32'd0);
        cycle(0, 0, 0, 0, 32'd0);
        do_reset("reset_in_halt");
        repeat (4) cycle(0, 0, 0, 0, 32'd0);

`ifdef FETCH_CTRL_PERFCNT_EN
        force dut.r_redirect_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_redirect_count;
        m_rc = 32'hFFFF_FFFF;
        cycle(0, 1, 0, 0, 32'h200);
        repeat (3) cycle(0, 0, 0, 0, 32'd0);
`endif

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("reset_random");
            end else begin
                cycle($urandom_range(0, 3) == 0,
                      $urandom_range(0, 6) == 0,
                      $urandom_range(0, 19) == 0,
                      $urandom_range(0, 2) == 0,
                      $urandom & 32'hFFFF_FFFC);
            end
        end

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the PC and branch target.
REQ-002 SHALL have parameter BOOT_CYCLES, default 2, the number of post-reset cycles before the first fetch; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port stall_req, input, 1 bit: the downstream cannot accept an instruction this cycle.
REQ-006 SHALL have port branch_taken, input, 1 bit: the execute stage resolved a taken branch or jump.
REQ-007 SHALL have port branch_target, input, DATA_WIDTH bits: the redirect address, valid while branch_taken=1.
REQ-008 SHALL have port halt_req, input, 1 bit: request to freeze fetch (ecall/ebreak/debug).
REQ-009 SHALL have port resume, input, 1 bit: single-cycle pulse that leaves HALT.
REQ-010 SHALL have port trigger, output, 1 bit: PC register write enable.
REQ-011 SHALL have port PCSrc, output, 1 bit: PC next-value select (0 = PC+4, 1 = PCTarget).
REQ-012 SHALL have port PCTarget, output, DATA_WIDTH bits: the latched redirect address.
REQ-013 SHALL have port flush, output, 1 bit: kill the instruction currently in fetch/decode.
REQ-014 SHALL have port fetch_valid, output, 1 bit: Instr from the fetch path is valid this cycle.
REQ-015 SHALL have port halted, output, 1 bit: the controller is in HALT.

Function
REQ-016 SHALL implement the FSM states BOOT, RUN, REDIRECT and HALT.
REQ-017 In BOOT, SHALL count from 0 to BOOT_CYCLES-1 with trigger=0 and fetch_valid=0, then go to RUN; all inputs are ignored in BOOT.
REQ-018 In RUN, SHALL drive fetch_valid=1 and PCSrc=0.
REQ-019 In RUN, SHALL drive trigger=1 combinationally only when stall_req, branch_taken and halt_req are all 0.
REQ-020 RUN priority SHALL be halt_req > branch_taken > stall_req.
REQ-021 RUN with halt_req=1 SHALL give trigger=0 and next state HALT; a simultaneous branch_taken SHALL be dropped.
REQ-022 RUN with branch_taken=1 and halt_req=0 SHALL latch branch_target into PCTarget, drive trigger=0, and go to REDIRECT, regardless of stall_req.
REQ-023 In REDIRECT, SHALL drive trigger=1, PCSrc=1, flush=1 and fetch_valid=0 for exactly one cycle.
REQ-024 REDIRECT SHALL ignore stall_req and branch_taken.
REQ-025 REDIRECT SHALL go next to HALT if halt_req=1, otherwise to RUN.
REQ-026 Redirect latency: PC SHALL equal branch_target after the second posedge following the sampling of branch_taken.
REQ-027 In HALT, SHALL drive halted=1, trigger=0 and fetch_valid=0, and ignore branch_taken and stall_req.
REQ-028 HALT SHALL go to RUN on the cycle after resume=1; if halt_req and resume are both 1, SHALL stay in HALT.
REQ-029 PCTarget SHALL hold its value except when loaded per REQ-022.
REQ-030 flush SHALL be 0 outside REDIRECT.
REQ-031 PCSrc SHALL be 0 outside REDIRECT.

Reset
REQ-032 rst=1 SHALL immediately force state BOOT, boot counter 0, PCTarget 0, and trigger, PCSrc, flush, fetch_valid and halted all 0, with counters (if present) at 0.
REQ-033 Reset asserted mid-REDIRECT or mid-HALT SHALL abandon the operation with no pending redirect.
REQ-034 After reset deasserts, the first trigger=1 SHALL occur in the cycle BOOT_CYCLES posedges later.

Configuration
REQ-035 With macro FETCH_CTRL_PERFCNT_EN defined, SHALL add output stall_cycles[31:0], counting RUN cycles with stall_req=1 and no branch/halt, saturating at 0xFFFFFFFF.
REQ-036 With FETCH_CTRL_PERFCNT_EN defined, SHALL add output redirect_count[31:0], incrementing on each REDIRECT entry, saturating at 0xFFFFFFFF.
REQ-037 Without FETCH_CTRL_PERFCNT_EN, the counter ports and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-038 Reset then release, BOOT_CYCLES=2 -> trigger=0 for 2 cycles, then trigger=1 and fetch_valid=1 from the 3rd cycle; PC steps 0,4,8.
REQ-039 RUN with stall_req=1 for 3 cycles -> trigger=0 for exactly those 3 cycles, PC held, fetch_valid=1; stall_cycles +3 when PERFCNT on.
REQ-040 branch_taken=1 with branch_target=0x40 -> next cycle PCSrc=1, flush=1, trigger=1, PCTarget=0x40; PC=0x40 after 2nd edge, then 0x44.
REQ-041 halt_req=1 and branch_taken=1 (target 0x80) together in RUN -> HALT, halted=1, PCTarget unchanged, PC frozen; resume pulse -> RUN next cycle, PC continues +4.
REQ-042 Assert rst during REDIRECT (target 0x100) -> all outputs 0 at once, PCTarget=0, BOOT re-entered, no redirect occurs after release.
REQ-043 Force redirect_count to 0xFFFFFFFF, then take a branch -> count stays 0xFFFFFFFF.
